// File: rtl/usb_rx_pkg.sv
// Shared constants and counter types for the USB full-speed receive path.
package usb_rx_pkg;

    localparam int USB_CLKS_PER_BIT  = 8;
    localparam int USB_SAMPLE_PHASE  = 3;
    localparam int USB_BITS_PER_BYTE = 8;

    typedef logic [$clog2(USB_CLKS_PER_BIT)-1:0]  clk_cnt_t;
    typedef logic [$clog2(USB_BITS_PER_BYTE)-1:0] bit_cnt_t;

endpackage

// File: rtl/rx_bit_timer_if.sv
// Link between the RX control side (drives rcving/d_edge) and the bit timer.
interface rx_bit_timer_if;
    import usb_rx_pkg::*;

    logic     rcving;
    logic     d_edge;
    logic     shift_enable;
    logic     byte_received;
    bit_cnt_t bit_idx;

    modport master (
        output rcving,
        output d_edge,
        input  shift_enable,
        input  byte_received,
        input  bit_idx
    );

    modport slave (
        input  rcving,
        input  d_edge,
        output shift_enable,
        output byte_received,
        output bit_idx
    );

endinterface

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear that wraps to 0 after reaching rollover_val.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    // Flag is a decode of the current count so the caller can act on the
    // same cycle as the final increment.
    assign rollover_flag = (count_out == rollover_val);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            if (rollover_flag)
                count_out <= '0;
            else
                count_out <= count_out + NUM_CNT_BITS'(1);
        end
    end

endmodule

// File: rtl/rx_bit_timer.sv
// USB full-speed RX bit timer: tracks bit phase, re-syncs on line edges,
// pulses shift_enable at mid-bit and byte_received after each full byte.
module rx_bit_timer
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT  = USB_CLKS_PER_BIT,
    parameter int SAMPLE_PHASE  = USB_SAMPLE_PHASE,
    parameter int BITS_PER_BYTE = USB_BITS_PER_BYTE
) (
    input  logic          clk,
    input  logic          n_rst,
    rx_bit_timer_if.slave bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(BITS_PER_BYTE);

    localparam logic [CW-1:0] PHASE_SAMPLE = CW'(SAMPLE_PHASE);
    localparam logic [CW-1:0] PHASE_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST     = BW'(BITS_PER_BYTE - 1);

    logic [CW-1:0] clk_cnt;
    logic [BW-1:0] bit_cnt;
    logic          at_sample;
    logic          shift_enable;
    logic          last_bit;
    logic          byte_received;

    assign at_sample    = (clk_cnt == PHASE_SAMPLE);
    assign shift_enable = bus.rcving && at_sample;

    // An edge landing on the sample phase is ignored, otherwise the reload
    // would produce a second sample inside the same bit.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            clk_cnt <= '0;
        end else if (!bus.rcving) begin
            clk_cnt <= '0;
        end else if (bus.d_edge && !at_sample) begin
            clk_cnt <= CW'(1);
        end else if (clk_cnt == PHASE_LAST) begin
            clk_cnt <= '0;
        end else begin
            clk_cnt <= clk_cnt + CW'(1);
        end
    end

    flex_counter #(
        .NUM_CNT_BITS (BW)
    ) u_bit_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (!bus.rcving),
        .count_enable  (shift_enable),
        .rollover_val  (BIT_LAST),
        .count_out     (bit_cnt),
        .rollover_flag (last_bit)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            byte_received <= 1'b0;
        else
            byte_received <= shift_enable && last_bit;
    end

    assign bus.shift_enable  = shift_enable;
    assign bus.byte_received = byte_received;
    assign bus.bit_idx       = bit_cnt;

endmodule

// File: tb/tb_rx_bit_timer.sv
// Scoreboard bench for rx_bit_timer: stimulus pushes expected pulses, a monitor matches them.
module tb_rx_bit_timer;

    typedef struct {
        int cyc;
        int idx;
    } ev_t;

    logic clk;
    logic n_rst;
    int   cyc;
    int   n_checks;
    int   n_fail;

    ev_t se_q[$];
    int  br_q[$];

    rx_bit_timer_if bus ();

    rx_bit_timer dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic drive(input logic rc, input logic de);
        @(posedge clk);
        #1;
        bus.rcving = rc;
        bus.d_edge = de;
    endtask

    task automatic run(input logic rc, input logic de, input int n);
        for (int i = 0; i < n; i++) drive(rc, de);
    endtask

    task automatic push_se(input int c, input int idx);
        ev_t e;
        e.cyc = c;
        e.idx = idx;
        se_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output pulse must match the head of its queue
    always @(negedge clk) begin
        ev_t e;
        int  b;
        while (se_q.size() > 0 && se_q[0].cyc < cyc) begin
            n_checks++;
            n_fail++;
            e = se_q.pop_front();
            $display("FAIL se_missed: no shift_enable seen, expected at cycle %0d", e.cyc);
        end
        while (br_q.size() > 0 && br_q[0] < cyc) begin
            n_checks++;
            n_fail++;
            b = br_q.pop_front();
            $display("FAIL br_missed: no byte_received seen, expected at cycle %0d", b);
        end
        if (bus.shift_enable !== 1'b0) begin
            n_checks++;
            if (se_q.size() == 0 || se_q[0].cyc != cyc) begin
                n_fail++;
                $display("FAIL se_unexpected: shift_enable=%b at cycle %0d, expected 0", bus.shift_enable, cyc);
            end else begin
                e = se_q.pop_front();
                check("se_bit_idx", int'(bus.bit_idx), e.idx);
            end
        end
        if (bus.byte_received !== 1'b0) begin
            n_checks++;
            if (br_q.size() == 0 || br_q[0] != cyc) begin
                n_fail++;
                $display("FAIL br_unexpected: byte_received=%b at cycle %0d, expected 0", bus.byte_received, cyc);
            end else begin
                b = br_q.pop_front();
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int t2;
        int k;
        int gap;
        cyc        = 0;
        n_checks   = 0;
        n_fail     = 0;
        n_rst      = 1'b0;
        bus.rcving = 1'b0;
        bus.d_edge = 1'b0;

        // Reset state
        run(0, 0, 2);
        check("rst_shift_enable", int'(bus.shift_enable), 0);
        check("rst_byte_received", int'(bus.byte_received), 0);
        check("rst_bit_idx", int'(bus.bit_idx), 0);
        n_rst = 1'b1;
        run(0, 0, 2);

        // Clean line: samples at 3,11,...,59 and byte_received at 60
        drive(1, 0);
        t = cyc;
        for (int i = 0; i < 8; i++) push_se(t + 3 + 8 * i, i);
        br_q.push_back(t + 60);
        run(1, 0, 63);
        run(0, 0, 2);

        // Async reset mid-count (clk_cnt=5, bit_cnt=4)
        drive(1, 0);
        t = cyc;
        for (int i = 0; i < 4; i++) push_se(t + 3 + 8 * i, i);
        run(1, 0, 29);
        #1;
        check("pre_rst_bit_idx", int'(bus.bit_idx), 4);
        n_rst = 1'b0;
        #1;
        check("midrst_shift_enable", int'(bus.shift_enable), 0);
        check("midrst_byte_received", int'(bus.byte_received), 0);
        check("midrst_bit_idx", int'(bus.bit_idx), 0);
        run(1, 0, 2);
        drive(1, 0);
        n_rst = 1'b1;
        t = cyc;
        push_se(t + 3, 0);
        run(1, 0, 4);
        run(0, 0, 2);

        // Edge at clk_cnt=6 re-aligns phase: samples at 3, 9, 17, ...
        drive(1, 0);
        t = cyc;
        push_se(t + 3, 0);
        for (int i = 1; i < 8; i++) push_se(t + 9 + 8 * (i - 1), i);
        br_q.push_back(t + 58);
        run(1, 0, 5);
        drive(1, 1);
        run(1, 0, 54);
        run(0, 0, 2);

        // Edge coincident with the sample phase is ignored
        drive(1, 0);
        t = cyc;
        push_se(t + 3, 0);
        push_se(t + 11, 1);
        push_se(t + 19, 2);
        run(1, 0, 2);
        drive(1, 1);
        run(1, 0, 17);
        run(0, 0, 2);

        // rcving dropped after 5 samples: partial byte discarded
        drive(1, 0);
        t = cyc;
        for (int i = 0; i < 5; i++) push_se(t + 3 + 8 * i, i);
        run(1, 0, 35);
        drive(0, 0);
        drive(0, 0);
        #1;
        check("drop_bit_idx", int'(bus.bit_idx), 0);
        drive(1, 0);
        t2 = cyc;
        for (int i = 0; i < 8; i++) push_se(t2 + 3 + 8 * i, i);
        br_q.push_back(t2 + 60);
        run(1, 0, 63);
        run(0, 0, 2);

        // Jittered line, 4 bytes; rcving falls right after the last sample
        drive(1, 0);
        for (int j = 0; j < 32; j++) begin
            drive(1, 1);
            k = cyc;
            push_se(k + 3, j % 8);
            if (j % 8 == 7) br_q.push_back(k + 4);
            if (j < 31) begin
                gap = int'($urandom_range(7, 9));
                run(1, 0, gap - 1);
            end else begin
                run(1, 0, 3);
                drive(0, 0);
            end
        end
        run(0, 0, 4);

        check("se_queue_empty", se_q.size(), 0);
        check("br_queue_empty", br_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
